// File: rtl/key_debounce.sv
// key_debounce: eight push-button inputs -> synchronised, debounced levels
// plus one-cycle press pulses.
// Optional auto-repeat on held keys is built when the macro
// KEY_AUTOREPEAT_EN is defined; without it no repeat logic exists.
module key_debounce #(
    parameter int         DEBOUNCE_CYC     = 20000,
    parameter int         KEY_ACTIVE_LOW   = 1,
    parameter int         REPEAT_DELAY_CYC = 500000,
    parameter int         REPEAT_RATE_CYC  = 100000,
    parameter logic [7:0] REPEAT_MASK      = 8'h30
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] KEY_RAW,
    output logic [7:0] KEY,
    output logic [7:0] KEY_LEVEL
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [7:0]       RAW_IDLE = (KEY_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_level;
    logic [7:0]       r_key;
    logic [CNT_W-1:0] r_cnt [8];

    logic [7:0]       w_pressed;
    logic [7:0]       w_toggle;
    logic [7:0]       w_level_next;
    logic [7:0]       w_rise;
    logic [7:0]       w_repeat;
    logic [CNT_W-1:0] w_cnt_next [8];

    // Two-flop synchroniser; idles at the released raw level in reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= KEY_RAW;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // Mismatch counters: count while input disagrees with the stable level,
    // toggle the level on the cycle the count would reach DEBOUNCE_CYC.
    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < 8; i++) begin
            w_cnt_next[i] = '0;
            if (w_pressed[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_TC) begin
                    w_toggle[i] = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_level_next = r_level ^ w_toggle;
    assign w_rise       = w_level_next & ~r_level;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                   : REPEAT_RATE_CYC;
    localparam int               REP_W     = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE_CYC - 1);

    logic [REP_W-1:0] r_rep [8];

    // Per-key repeat down-counter: loaded on the press, fires at zero and
    // reloads with the rate; held at zero while the key is released.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < 8; i++) r_rep[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!REPEAT_MASK[i] || !w_level_next[i]) begin
                    r_rep[i] <= '0;
                end else if (w_rise[i]) begin
                    r_rep[i] <= REP_DELAY;
                end else if (r_rep[i] == '0) begin
                    r_rep[i] <= REP_RATE;
                end else begin
                    r_rep[i] <= r_rep[i] - REP_W'(1);
                end
            end
        end
    end

    // A repeat fires only on a held key whose timer has run out.
    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < 8; i++) begin
            w_repeat[i] = REPEAT_MASK[i] && w_level_next[i] && r_level[i]
                          && (r_rep[i] == '0);
        end
    end
`else
    assign w_repeat = 8'h00;
`endif

    // Stable levels, counters and registered pulse outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_level <= '0;
            r_key   <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            r_level <= w_level_next;
            r_key   <= w_rise | w_repeat;
            for (int i = 0; i < 8; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    assign KEY       = r_key;
    assign KEY_LEVEL = r_level;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: scenario tasks plus a window-based reference model
// of the debounce and repeat rules.
module tb_key_debounce;

    localparam int         DB    = 4;
    localparam int         RD    = 10;
    localparam int         RR    = 3;
    localparam logic [7:0] RMASK = 8'h30;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] KEY_RAW;
    logic [7:0] KEY;
    logic [7:0] KEY_LEVEL;

    int errors = 0;
    int checks = 0;

    key_debounce #(
        .DEBOUNCE_CYC    (DB),
        .KEY_ACTIVE_LOW  (1),
        .REPEAT_DELAY_CYC(RD),
        .REPEAT_RATE_CYC (RR),
        .REPEAT_MASK     (RMASK)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .KEY_RAW  (KEY_RAW),
        .KEY      (KEY),
        .KEY_LEVEL(KEY_LEVEL)
    );

    always #5 CLK = ~CLK;

    // Reference model: the input seen by the debouncer on edge n is the raw
    // value sampled two edges earlier. A level flips when the last DB seen
    // values all disagree with it. Repeats follow from the age of the press.
    logic [7:0] m_hist [0:DB+1];
    logic [7:0] m_level, m_key, m_new;
    int         m_age [8];
    bit         m_diff;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int j = 0; j <= DB + 1; j++) m_hist[j] = 8'h00;
            m_level = 8'h00;
            m_key   = 8'h00;
            for (int i = 0; i < 8; i++) m_age[i] = 0;
        end else begin
            for (int j = DB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = ~KEY_RAW;
            m_new = m_level;
            m_key = 8'h00;
            for (int i = 0; i < 8; i++) begin
                m_diff = 1'b1;
                for (int j = 2; j <= DB + 1; j++)
                    if (m_hist[j][i] == m_level[i]) m_diff = 1'b0;
                if (m_diff) m_new[i] = ~m_level[i];
                if (m_new[i] && !m_level[i]) begin
                    m_key[i] = 1'b1;
                    m_age[i] = 0;
                end else if (m_new[i]) begin
                    m_age[i]++;
                    if (REP_EN && RMASK[i] && m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0)
                        m_key[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
            end
            m_level = m_new;
        end
    end

    task automatic test_reset();
        RESETN  = 1'b0;
        KEY_RAW = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== 8'h00 || KEY_LEVEL !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold key=%h level=%h want 00/00", KEY, KEY_LEVEL);
            end
        end
        KEY_RAW = 8'hFF;
        RESETN  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL reset_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulse_at, pulses, fall_at;
        pulse_at = -1; pulses = 0; fall_at = -1;
        KEY_RAW[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL press_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
            end
            if (KEY[0]) begin pulses++; if (pulse_at < 0) pulse_at = k; end
        end
        checks++;
        if (pulse_at != DB + 2 || pulses != 1) begin
            errors++;
            $display("FAIL press_pulse edge=%0d count=%0d want edge=%0d count=1", pulse_at, pulses, DB + 2);
        end
        checks++;
        if (KEY_LEVEL[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_level got %b want 1", KEY_LEVEL[0]);
        end
        KEY_RAW[0] = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL release_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
            end
            if (KEY[0]) pulses++;
            if (!KEY_LEVEL[0] && fall_at < 0) fall_at = k;
        end
        checks++;
        if (fall_at != DB + 2 || pulses != 0) begin
            errors++;
            $display("FAIL release edge=%0d pulses=%0d want edge=%0d pulses=0", fall_at, pulses, DB + 2);
        end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                KEY_RAW[1] = (k == 3);
                @(posedge CLK); @(negedge CLK);
                checks++;
                if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                    errors++;
                    $display("FAIL bounce_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
                end
                if (KEY[1] || KEY_LEVEL[1]) seen++;
            end
        end
        KEY_RAW[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (KEY[1] || KEY_LEVEL[1]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL bounce_quiet active_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_simultaneous();
        int hit;
        hit = -1;
        KEY_RAW[2] = 1'b0;
        KEY_RAW[7] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL simul_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
            end
            if (k == DB + 2) begin
                checks++;
                if (KEY !== 8'h84) begin
                    errors++;
                    $display("FAIL simul_pulse key=%h want 84", KEY);
                end
            end else if (KEY !== 8'h00) begin
                hit = k;
            end
        end
        checks++;
        if (hit >= 0) begin
            errors++;
            $display("FAIL simul_extra stray pulse at edge %0d want none", hit);
        end
        KEY_RAW = 8'hFF;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int pulse_at, pulses;
        pulse_at = -1; pulses = 0;
        KEY_RAW[3] = 1'b0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== 8'h00 || KEY_LEVEL !== 8'h00) begin
                errors++;
                $display("FAIL midreset_hold key=%h level=%h want 00/00", KEY, KEY_LEVEL);
            end
        end
        RESETN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL midreset_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
            end
            if (KEY[3]) begin pulses++; if (pulse_at < 0) pulse_at = k; end
        end
        checks++;
        if (pulse_at != DB + 2 || pulses != 1) begin
            errors++;
            $display("FAIL midreset_pulse edge=%0d count=%0d want edge=%0d count=1", pulse_at, pulses, DB + 2);
        end
        KEY_RAW = 8'hFF;
        repeat (10) @(negedge CLK);
    endtask

    // Hold key b so its level drops exactly 25 edges after the press pulse.
    task automatic test_autorepeat(input int b);
        int offs[$];
        int want[$];
        int found;
        found = 0;
        if (REP_EN && RMASK[b]) want = '{0, 10, 13, 16, 19, 22};
        else want = '{0};
        KEY_RAW[b] = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (KEY[b]) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_press key%0d no press pulse within 20 cycles", b);
        end else begin
            offs.push_back(0);
            for (int off = 1; off <= 35; off++) begin
                if (off == 20) KEY_RAW[b] = 1'b1;
                @(posedge CLK); @(negedge CLK);
                checks++;
                if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                    errors++;
                    $display("FAIL repeat_model key=%h want %h level=%h want %h", KEY, m_key, KEY_LEVEL, m_level);
                end
                if (KEY[b]) offs.push_back(off);
            end
            checks++;
            if (offs.size() != want.size()) begin
                errors++;
                $display("FAIL repeat_count key%0d pulses=%0d want %0d", b, offs.size(), want.size());
            end else begin
                foreach (want[i]) begin
                    checks++;
                    if (offs[i] != want[i]) begin
                        errors++;
                        $display("FAIL repeat_offset key%0d pulse%0d at +%0d want +%0d", b, i, offs[i], want[i]);
                    end
                end
            end
        end
        KEY_RAW[b] = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) KEY_RAW[i] = ~KEY_RAW[i];
            RESETN = ($urandom_range(0, 299) != 0);
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (KEY !== m_key || KEY_LEVEL !== m_level) begin
                errors++;
                $display("FAIL random_model cyc=%0d key=%h want %h level=%h want %h", c, KEY, m_key, KEY_LEVEL, m_level);
            end
        end
        RESETN = 1'b1;
    endtask

    initial begin
        RESETN  = 1'b0;
        KEY_RAW = 8'hFF;
        @(negedge CLK);
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat(4);
        test_autorepeat(0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 20000: consecutive stable cycles required to accept a level change (min 2).
REQ-002 SHALL have parameter KEY_ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
REQ-003 SHALL have parameter REPEAT_DELAY_CYC, default 500000: cycles from the press pulse to the first repeat pulse.
REQ-004 SHALL have parameter REPEAT_RATE_CYC, default 100000: cycles between subsequent repeat pulses (min 1).
REQ-005 SHALL have parameter REPEAT_MASK, default 8'h30: keys eligible for auto-repeat (bit i = key i).
REQ-006 SHALL have port CLK  input  1: single system clock; all state on its rising edge.
REQ-007 SHALL have port RESETN  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port KEY_RAW  input  8: raw, asynchronous, bouncing push-button inputs.
REQ-009 SHALL have port KEY  output  8: one-cycle press/repeat pulses, active-high, consumed by the key controller.
REQ-010 SHALL have port KEY_LEVEL  output  8: debounced pressed state, active-high.

Function
REQ-011 SHALL pass each KEY_RAW bit through a 2-flop synchronizer and normalise polarity per KEY_ACTIVE_LOW, so that 1 = pressed.
REQ-012 SHALL keep, per key, an independent stable level and a mismatch counter of width $clog2(DEBOUNCE_CYC+1).
REQ-013 SHALL increment the counter each cycle the synchronized value differs from the stable level, and SHALL clear it on any cycle they match.
REQ-014 SHALL, on the cycle the counter would reach DEBOUNCE_CYC, toggle the stable level and clear the counter.
REQ-015 SHALL assert KEY[i] for exactly one cycle, registered, on the edge where stable level i changes 0->1; the pulse therefore appears DEBOUNCE_CYC+2 edges after the first edge that samples the new raw level.
REQ-016 SHALL generate no pulse on release (1->0); KEY_LEVEL[i] SHALL equal stable level i, registered.
REQ-017 SHALL ignore bounces shorter than DEBOUNCE_CYC consecutive cycles: counter cleared, no level change, no pulse.
REQ-018 SHALL process keys fully independently, so simultaneous presses MAY pulse multiple KEY bits in the same cycle, with no priority or masking.
REQ-019 SHALL keep KEY at 0 for any key whose stable level is 0.

Reset
REQ-020 SHALL, while RESETN=0, force synchronizer flops to the released value and clear stable levels, counters, repeat timers, KEY and KEY_LEVEL to 0.
REQ-021 SHALL abort any debounce or repeat in progress when reset is asserted mid-operation, with no pulse emitted.
REQ-022 SHALL treat a key held through reset release as a new press: one pulse DEBOUNCE_CYC+2 edges after release.

Configuration
REQ-023 SHALL, with macro KEY_AUTOREPEAT_EN defined, keep a per-key repeat timer for keys in REPEAT_MASK that are stably pressed: first repeat pulse REPEAT_DELAY_CYC cycles after the press pulse, then one every REPEAT_RATE_CYC cycles, until release.
REQ-024 SHALL, with KEY_AUTOREPEAT_EN defined, clear the repeat timer on release; a re-press restarts from REPEAT_DELAY_CYC.
REQ-025 SHALL, without KEY_AUTOREPEAT_EN, synthesize no repeat logic, ignore REPEAT_* and REPEAT_MASK, and emit exactly one pulse per accepted press.

Verification
Bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, KEY_ACTIVE_LOW=1.
REQ-026 Clean press: KEY_RAW[0] 1->0 and held -> KEY[0] single pulse 6 edges after the first sampling edge, KEY_LEVEL[0]=1; release -> KEY_LEVEL[0]=0 after 6 edges, no pulse.
REQ-027 Bounce: KEY_RAW[1] toggles low 3 cycles, high 1 cycle, repeated 5 times, then high -> KEY[1] and KEY_LEVEL[1] remain 0.
REQ-028 Simultaneous keys: KEY_RAW[2] and KEY_RAW[7] fall on the same edge -> KEY=8'h84 for one cycle.
REQ-029 Reset mid-debounce: RESETN low 2 cycles after KEY_RAW[3] falls -> no pulse; KEY_RAW[3] still low at reset release -> one pulse 6 edges later.
REQ-030 Autorepeat (KEY_AUTOREPEAT_EN defined): KEY_RAW[4] held 25 cycles past the press pulse -> pulses at +0, +10, +13, +16, +19, +22; KEY_RAW[0] held the same way -> only the +0 pulse.
REQ-031 Macro undefined: repeat the REQ-030 stimulus -> only the +0 pulse on KEY[4].
